// File: rtl/pcm_dac_master.sv
// Clock master and left-justified serialiser for a stereo 24-bit DAC.
// scki/bck/lrck are registered outputs produced by enables on clk_40MHz; no derived clocks.
module pcm_dac_master #(
    parameter int BCK_HALF_DIV = 4,
    parameter int DATA_WIDTH   = 24,
    parameter int SLOT_BITS    = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk_40MHz,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_left,
    input  logic [DATA_WIDTH-1:0]       in_right,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        scki,
    output logic                        bck,
    output logic                        lrck,
    output logic                        dout,
    output logic                        frame_start,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int DIV_W = (BCK_HALF_DIV > 1) ? $clog2(BCK_HALF_DIV) : 1;
    localparam int BIT_W = $clog2(SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);

    logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  scki_q, bck_q, bck_d, lrck_q, lrck_d, dout_q, dout_d;
    logic                  fs_q, ur_q;
    logic [DATA_WIDTH-1:0] shl_q, shl_d, shr_q, shr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         level_q, level_d;

    logic                  bck_fall, slot_wrap, frame_load, fifo_empty, push, pop;
    logic [DATA_WIDTH-1:0] cur_word, cur_sh;

    assign in_ready    = (level_q < LW'(FIFO_DEPTH));
    assign scki        = scki_q;
    assign bck         = bck_q;
    assign lrck        = lrck_q;
    assign dout        = dout_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;
    assign fifo_level  = level_q;

    always_comb begin
        bck_fall   = bck_q && (div_q == DIV_LAST);
        slot_wrap  = bck_fall && (bit_q == BIT_LAST);
        frame_load = slot_wrap && lrck_q;
        fifo_empty = (level_q == '0);
        push       = in_valid && in_ready;
        pop        = frame_load && !fifo_empty;

        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        bck_d  = (div_q == DIV_LAST) ? ~bck_q : bck_q;
        bit_d  = bit_q;
        lrck_d = lrck_q;
        if (bck_fall) begin
            bit_d = slot_wrap ? '0 : bit_q + 1'b1;
        end
        if (slot_wrap) begin
            lrck_d = ~lrck_q;
        end

        // The shadow pair is loaded on the same edge that emits its MSB, so dout reads the _d side.
        shl_d = shl_q;
        shr_d = shr_q;
        if (frame_load) begin
            shl_d = pop ? mem_l[rd_ptr_q] : '0;
            shr_d = pop ? mem_r[rd_ptr_q] : '0;
        end
        cur_word = lrck_d ? shr_d : shl_d;
        cur_sh   = cur_word << bit_d;
        dout_d   = bck_fall ? cur_sh[DATA_WIDTH-1] : dout_q;

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_40MHz or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            bit_q    <= BIT_LAST;
            scki_q   <= 1'b0;
            bck_q    <= 1'b0;
            lrck_q   <= 1'b1;
            dout_q   <= 1'b0;
            fs_q     <= 1'b0;
            ur_q     <= 1'b0;
            shl_q    <= '0;
            shr_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            scki_q   <= ~scki_q;
            bck_q    <= bck_d;
            lrck_q   <= lrck_d;
            dout_q   <= dout_d;
            fs_q     <= frame_load;
            ur_q     <= frame_load && fifo_empty;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk_40MHz) begin
        if (push) begin
            mem_l[wr_ptr_q] <= in_left;
            mem_r[wr_ptr_q] <= in_right;
        end
    end

endmodule
